// File: rtl/w_word_loader.sv
// SPI-mode-0 slave that validates 16-bit command frames and loads switch word W; W updates SYNC_STAGES+3 clk after cs_n rises.
// No backpressure: decoderDone gates the W update and w_reset strobe, and frames arriving meanwhile overwrite the single pending slot.
module w_word_loader #(
   parameter int W_WIDTH       = 13,
   parameter int MAX_W         = 6479,
   parameter int STROBE_CYCLES = 2,
   parameter int SYNC_STAGES   = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               sck,
   input  logic               cs_n,
   input  logic               mosi,
   output logic               miso,
   input  logic               decoderDone,
   output logic [W_WIDTH-1:0] W,
   output logic               w_reset,
   output logic [3:0]         err
);

   localparam int SCW = $clog2(STROBE_CYCLES + 1);
   localparam logic [W_WIDTH-1:0] MAX_V = W_WIDTH'(MAX_W);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_CHECK,
      ST_WAIT,
      ST_STROBE
   } state_t;

   state_t state, state_nxt, rx_nxt;

   logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
   logic                   sck_q, cs_q;
   logic                   sck_s, cs_s, mosi_s;
   logic                   sck_rise, sck_fall, cs_rise, cs_fall;

   logic        rx_on, chk;
   logic [4:0]  bit_cnt;
   logic [15:0] rx_sh, tx_sh, tx_load;

   logic [W_WIDTH-1:0] pend_dat;
   logic               pend_vld;
   logic [SCW-1:0]     s_cnt, boot_cnt;
   logic               consume;

   logic [2:0]         f_cmd;
   logic [W_WIDTH-1:0] f_val;
   logic               len_ok, is_wr, is_nop, is_clr;
   logic               len_set, cmd_set, rng_set, ovr_set, wr_ok, clr;
   logic [3:0]         err_nxt;

   assign sck_s  = sck_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   assign sck_rise = sck_s & ~sck_q;
   assign sck_fall = ~sck_s & sck_q;
   assign cs_rise  = cs_s & ~cs_q;
   assign cs_fall  = ~cs_s & cs_q;

   // cs chain resets low so that a pin already low at release is not taken as a new frame start
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sck_sync  <= '0;
         cs_sync   <= '0;
         mosi_sync <= '0;
         sck_q     <= 1'b0;
         cs_q      <= 1'b0;
      end else begin
         sck_sync[0]  <= sck;
         cs_sync[0]   <= cs_n;
         mosi_sync[0] <= mosi;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sck_sync[i]  <= sck_sync[i-1];
            cs_sync[i]   <= cs_sync[i-1];
            mosi_sync[i] <= mosi_sync[i-1];
         end
         sck_q <= sck_s;
         cs_q  <= cs_s;
      end
   end

   assign tx_load = {3'b101, W};

   // Receive/transmit path runs in every state, so it also acts as the shadow receiver
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_on   <= 1'b0;
         chk     <= 1'b0;
         bit_cnt <= '0;
         rx_sh   <= '0;
         tx_sh   <= '0;
         miso    <= 1'b0;
      end else begin
         chk <= cs_rise & rx_on;
         if (cs_fall) begin
            rx_on   <= 1'b1;
            bit_cnt <= '0;
            miso    <= tx_load[15];
            tx_sh   <= {tx_load[14:0], 1'b0};
         end else if (cs_rise) begin
            rx_on <= 1'b0;
            miso  <= 1'b0;
         end else if (rx_on) begin
            if (sck_rise) begin
               rx_sh <= {rx_sh[14:0], mosi_s};
               if (bit_cnt != 5'd17)
                  bit_cnt <= bit_cnt + 5'd1;
            end
            if (sck_fall) begin
               miso  <= tx_sh[15];
               tx_sh <= {tx_sh[14:0], 1'b0};
            end
         end
      end
   end

   assign f_cmd   = rx_sh[15:13];
   assign f_val   = rx_sh[W_WIDTH-1:0];
   assign len_ok  = (bit_cnt == 5'd16);
   assign is_wr   = (f_cmd == 3'b001);
   assign is_nop  = (f_cmd == 3'b010);
   assign is_clr  = (f_cmd == 3'b111);

   assign len_set = chk & ~len_ok;
   assign cmd_set = chk & len_ok & ~(is_wr | is_nop | is_clr);
   assign rng_set = chk & len_ok & is_wr & (f_val > MAX_V);
   assign wr_ok   = chk & len_ok & is_wr & (f_val <= MAX_V);
   assign clr     = chk & len_ok & is_clr;
   assign ovr_set = wr_ok & pend_vld & ~consume;
   assign err_nxt = (clr ? 4'b0000 : err) | {ovr_set, rng_set, cmd_set, len_set};

   always_comb begin
      rx_nxt = ST_IDLE;
      if (wr_ok)
         rx_nxt = ST_WAIT;
      else if (cs_rise && rx_on)
         rx_nxt = ST_CHECK;
      else if (cs_fall || rx_on)
         rx_nxt = ST_SHIFT;
   end

   always_comb begin
      state_nxt = state;
      consume   = 1'b0;
      case (state)
         ST_IDLE, ST_SHIFT, ST_CHECK: state_nxt = rx_nxt;
         ST_WAIT: begin
            if (decoderDone) begin
               state_nxt = ST_STROBE;
               consume   = 1'b1;
            end
         end
         ST_STROBE: begin
            if (s_cnt == SCW'(STROBE_CYCLES - 1))
               state_nxt = pend_vld ? ST_WAIT : rx_nxt;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // boot_cnt stretches w_reset for STROBE_CYCLES cycles after reset release
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         W        <= '0;
         w_reset  <= 1'b1;
         err      <= '0;
         pend_vld <= 1'b0;
         pend_dat <= '0;
         s_cnt    <= '0;
         boot_cnt <= SCW'(STROBE_CYCLES);
      end else begin
         state   <= state_nxt;
         w_reset <= (state_nxt == ST_STROBE) || (boot_cnt > SCW'(1));
         if (boot_cnt != '0)
            boot_cnt <= boot_cnt - SCW'(1);
         s_cnt <= (state == ST_STROBE) ? s_cnt + SCW'(1) : '0;
         if (consume)
            W <= pend_dat;
         if (wr_ok) begin
            pend_dat <= f_val;
            pend_vld <= 1'b1;
         end else if (consume) begin
            pend_vld <= 1'b0;
         end
         err <= err_nxt;
      end
   end

endmodule
